rdi_sb_msg_arbiter: RTL and testbench
=====================================

# rdi_sb_msg_arbiter

Shares the single RDI sideband message transmit channel between several RDI-side message sources: PM entry TX, PM entry RX, and the link-management responders. Each requester holds a level `valid` plus a 4-bit message number. The arbiter grants round-robin, forwards one message at a time to the sideband, and returns the sideband's completion to the granted requester as that requester's `i_msg_done`. A watchdog aborts any message the sideband does not complete within a clock-ratio-dependent limit.

## Interface
- `N_REQ`, 2: number of requesters (2..4).
- `MSG_W`, 4: message number width.
- `TO_CYC_DIV8`, 800: watchdog limit in cycles when `i_clk_div_ratio`=0 (100 MHz, 8 µs).
- `TO_CYC_DIV4`, 1600: watchdog limit in cycles when `i_clk_div_ratio`=1 (200 MHz, 8 µs).

Ports:
- `i_clk`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `i_rst`  in  1  synchronous active-high reset.
- `i_clk_div_ratio`  in  1  0: 100 MHz, 1: 200 MHz. Sampled at grant.
- `i_req_valid`  in  N_REQ  per-requester message request, held until done.
- `i_req_msg_no`  in  N_REQ*MSG_W  message numbers; requester k occupies bits [k*MSG_W +: MSG_W].
- `o_req_done`  out  N_REQ  one-cycle pulse to the granted requester when the sideband completes.
- `o_req_timeout`  out  N_REQ  one-cycle pulse to the granted requester on watchdog abort.
- `o_grant`  out  N_REQ  one-hot grant; all zero when no message is in flight.
- `o_sb_msg_valid`  out  1  message valid to the sideband.
- `o_sb_msg_no`  out  MSG_W  message number to the sideband.
- `i_sb_msg_done`  in  1  sideband completion, single-cycle.
- `o_busy`  out  1  high when the state is not IDLE.

## Operation
- States are IDLE, SEND and RELEASE.
- Round-robin pointer `last`:
  - Reset value is N_REQ-1, so requester 0 wins the first tie.
  - Search order is last+1, last+2, … modulo N_REQ.
- **IDLE.** If any `i_req_valid` bit is set, pick the winner g.
  - Register `o_grant`=onehot(g), `o_sb_msg_no`=msg_no[g], `o_sb_msg_valid`=1.
  - Latch the watchdog limit from `i_clk_div_ratio`, clear the timer, set `last`=g, go to SEND.
- **SEND.** `o_sb_msg_valid` is held at 1 and the timer increments every cycle. Exit priority:
  1. `i_sb_msg_done`=1: `o_sb_msg_valid`<=0, `o_req_done[g]`<=1, go to RELEASE.
  2. `i_req_valid[g]`=0 (requester withdrew): `o_sb_msg_valid`<=0, go to RELEASE, no done pulse.
  3. timer == limit-1: `o_sb_msg_valid`<=0, `o_req_timeout[g]`<=1, go to RELEASE.
- **RELEASE.**
  - Clear `o_grant`, `o_sb_msg_no`, `o_req_done` and `o_req_timeout`.
  - Always go to IDLE. No arbitration happens in this state. This cycle lets the served requester drop `valid` after seeing its done pulse.
- Latching and ignored inputs:
  - `o_sb_msg_no` is latched at grant. Changes on `i_req_msg_no` during SEND are ignored.
  - `i_sb_msg_done` is ignored in IDLE and RELEASE.
  - Non-granted requests wait; they are never dropped.
- The timer is `$clog2(max(TO_CYC_DIV8,TO_CYC_DIV4))` bits wide and never wraps: SEND always exits at limit-1.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `last`=N_REQ-1, timer 0.
- Reset asserted mid-SEND:
  - `o_sb_msg_valid` drops on the next edge.
  - No done or timeout pulse is issued.
- Request-to-valid latency is 1 cycle: `i_req_valid` is seen high at edge n, and `o_sb_msg_valid`=1 after edge n.
- Done-to-requester latency is 1 cycle: `i_sb_msg_done` high at edge m gives `o_req_done[g]`=1 and `o_sb_msg_valid`=0 after edge m.
- Minimum spacing between consecutive grants is 2 cycles: the done edge, then RELEASE, then IDLE grants.
- Watchdog: `o_sb_msg_valid` stays high for exactly the limit in cycles (800 or 1600), then drops in the same edge that pulses `o_req_timeout`.
- `i_sb_msg_done` and the watchdog limit in the same cycle resolve as done (no timeout).
- `i_sb_msg_done` and withdrawal in the same cycle resolve as done.
- `o_busy` is combinational from the state and is high in SEND and RELEASE.

## Test plan
- **Single request.** Req0 raises valid with msg_no=2; sideband returns done 5 cycles after valid. Required:
  - `o_sb_msg_no`=2 one cycle after the request.
  - `o_req_done`=01 for one cycle, then `o_grant`=00.
  - Req0 drops valid and no second grant occurs.
- **Tie after reset.** Req0 (msg 9) and req1 (msg 10) both request. Required:
  - Req0 is granted first.
  - After its done, RELEASE, IDLE, then req1 is granted with `o_sb_msg_no`=10.
  - Exactly 2 cycles separate the first `o_sb_msg_valid` falling edge from the second rising edge.
- **Round robin.** Both requesters hold valid continuously and reassert after each done. Required: grants alternate 0,1,0,1 over 4 messages.
- **Watchdog.**
  - With `i_clk_div_ratio`=0 and no `i_sb_msg_done`: `o_sb_msg_valid` is high for exactly 800 cycles, `o_req_timeout[g]` pulses once, and `o_req_done` stays 0.
  - Repeat with ratio=1: 1600 cycles.
- **Simultaneous events.**
  - Done on cycle 799 of the watchdog gives a done pulse with no timeout.
  - Withdrawal in the same cycle as done gives a done pulse.
  - Withdrawal alone gives no pulses and the arbiter returns to IDLE.
- **Reset mid-SEND.** Assert `i_rst` at cycle 3 of SEND. Required:
  - All outputs are 0 next cycle.
  - After release with both requesting, req0 is granted first (pointer reset).

Source files
------------

// File: rtl/rdi_sb_msg_arbiter.sv
// Round-robin arbiter sharing the RDI sideband message channel between requesters.
// One message in flight at a time, with a clock-ratio-dependent watchdog abort.
module rdi_sb_msg_arbiter #(
    parameter int N_REQ       = 2,
    parameter int MSG_W       = 4,
    parameter int TO_CYC_DIV8 = 800,
    parameter int TO_CYC_DIV4 = 1600
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clk_div_ratio,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*MSG_W-1:0] i_req_msg_no,
    output logic [N_REQ-1:0]       o_req_done,
    output logic [N_REQ-1:0]       o_req_timeout,
    output logic [N_REQ-1:0]       o_grant,
    output logic                   o_sb_msg_valid,
    output logic [MSG_W-1:0]       o_sb_msg_no,
    input  logic                   i_sb_msg_done,
    output logic                   o_busy
);

    localparam int LW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_MAX = (TO_CYC_DIV8 > TO_CYC_DIV4) ? TO_CYC_DIV8 : TO_CYC_DIV4;
    localparam int TW     = $clog2(TO_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      last_q, last_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [TW-1:0]      limit_q, limit_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   timeout_q, timeout_d;
    logic               valid_q, valid_d;
    logic [MSG_W-1:0]   msg_no_q, msg_no_d;

    logic               win_found;
    logic [LW-1:0]      win_idx;

    // Search starts just after the last winner, wrapping modulo N_REQ.
    always_comb begin
        int k;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(last_q) + i) % N_REQ;
            if (!win_found && i_req_valid[k]) begin
                win_found = 1'b1;
                win_idx   = LW'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        timer_d   = timer_q;
        limit_d   = limit_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        msg_no_d  = msg_no_q;
        done_d    = '0;
        timeout_d = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d  = N_REQ'(1) << win_idx;
                    msg_no_d = i_req_msg_no[int'(win_idx)*MSG_W +: MSG_W];
                    valid_d  = 1'b1;
                    limit_d  = i_clk_div_ratio ? TW'(TO_CYC_DIV4 - 1)
                                               : TW'(TO_CYC_DIV8 - 1);
                    timer_d  = '0;
                    last_d   = win_idx;
                    state_d  = SEND;
                end
            end
            SEND: begin
                timer_d = timer_q + 1'b1;
                if (i_sb_msg_done) begin
                    valid_d = 1'b0;
                    done_d  = grant_q;
                    state_d = RELEASE;
                end else if (~|(i_req_valid & grant_q)) begin
                    valid_d = 1'b0;
                    state_d = RELEASE;
                end else if (timer_q == limit_q) begin
                    valid_d   = 1'b0;
                    timeout_d = grant_q;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                grant_d  = '0;
                msg_no_d = '0;
                timer_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            last_q    <= LW'(N_REQ - 1);
            timer_q   <= '0;
            limit_q   <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            msg_no_q  <= '0;
            done_q    <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            limit_q   <= limit_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            msg_no_q  <= msg_no_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_grant        = grant_q;
    assign o_sb_msg_valid = valid_q;
    assign o_sb_msg_no    = msg_no_q;
    assign o_req_done     = done_q;
    assign o_req_timeout  = timeout_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rdi_sb_msg_arbiter.sv
// Bench for rdi_sb_msg_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_rdi_sb_msg_arbiter;

    localparam int N  = 2;
    localparam int MW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ratio = 1'b0;
    logic            sbdone = 1'b0;
    logic [N-1:0]    rv = '0;
    logic [N*MW-1:0] msg = '0;
    logic [N-1:0]    o_req_done, o_req_timeout, o_grant;
    logic            o_sb_msg_valid, o_busy;
    logic [MW-1:0]   o_sb_msg_no;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rdi_sb_msg_arbiter #(
        .N_REQ(N), .MSG_W(MW), .TO_CYC_DIV8(800), .TO_CYC_DIV4(1600)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_clk_div_ratio(ratio),
        .i_req_valid(rv),
        .i_req_msg_no(msg),
        .o_req_done(o_req_done),
        .o_req_timeout(o_req_timeout),
        .o_grant(o_grant),
        .o_sb_msg_valid(o_sb_msg_valid),
        .o_sb_msg_no(o_sb_msg_no),
        .i_sb_msg_done(sbdone),
        .o_busy(o_busy)
    );

    typedef struct {
        logic       r;
        logic [1:0] rv;
        logic [7:0] msg;
        logic       sbd;
        logic [1:0] g;
        logic       v;
        logic [3:0] m;
        logic [1:0] d;
        logic [1:0] t;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(logic r, logic [1:0] rv_i, logic [7:0] msg_i,
                                 logic sbd, logic [1:0] g, logic v, logic [3:0] m,
                                 logic [1:0] d, logic [1:0] t, logic b);
        vec_t x;
        x.r = r; x.rv = rv_i; x.msg = msg_i; x.sbd = sbd;
        x.g = g; x.v = v; x.m = m; x.d = d; x.t = t; x.b = b;
        return x;
    endfunction

    function automatic logic [11:0] outs();
        return {o_grant, o_sb_msg_valid, o_sb_msg_no, o_req_done, o_req_timeout, o_busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks who owns the channel, how long the message
    // has been on the wire, and a one-cycle cool-down after each message.
    int         m_owner, m_age, m_lim, m_last;
    bit         m_cool;
    logic [1:0] e_g, e_d, e_t;
    logic       e_v, e_b;
    logic [3:0] e_m;

    task automatic model_step();
        e_d = '0;
        e_t = '0;
        if (rst) begin
            m_owner = -1; m_cool = 0; m_last = N - 1;
            e_g = '0; e_v = 0; e_m = '0;
        end else if (m_cool) begin
            m_cool = 0; e_g = '0; e_m = '0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_last + i) % N;
                if (m_owner < 0 && rv[k]) m_owner = k;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                e_g = 2'(1 << m_owner);
                e_v = 1;
                e_m = msg[m_owner*MW +: MW];
                m_age = 1;
                m_lim = ratio ? 1600 : 800;
            end
        end else begin
            if (sbdone) begin
                e_d = e_g; e_v = 0; m_cool = 1; m_owner = -1;
            end else if (!rv[m_owner]) begin
                e_v = 0; m_cool = 1; m_owner = -1;
            end else if (m_age == m_lim) begin
                e_t = e_g; e_v = 0; m_cool = 1; m_owner = -1;
            end else begin
                m_age++;
            end
        end
        e_b = (m_owner >= 0) || m_cool;
    endtask

    initial begin
        int hi, tos, dns, got;

        // rst rv msg sbd | grant v msg done to busy
        tbl.push_back(mkv(1, 2'b00, 8'h00, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b01, 8'h02, 0, 2'b01, 1, 4'h2, 2'b00, 2'b00, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mkv(0, 2'b01, 8'h02, 0, 2'b01, 1, 4'h2, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b01, 8'h02, 1, 2'b01, 0, 4'h2, 2'b01, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b00, 8'h02, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b00, 8'h02, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(1, 2'b11, 8'hA9, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b11, 8'hA9, 0, 2'b01, 1, 4'h9, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b11, 8'hA9, 1, 2'b01, 0, 4'h9, 2'b01, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b10, 8'hA9, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b10, 8'hA9, 0, 2'b10, 1, 4'hA, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b10, 8'hA9, 1, 2'b10, 0, 4'hA, 2'b10, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b00, 8'hA9, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b01, 8'h05, 0, 2'b01, 1, 4'h5, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b00, 8'h05, 0, 2'b01, 0, 4'h5, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b00, 8'h05, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b10, 8'h35, 0, 2'b10, 1, 4'h3, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b00, 8'h35, 1, 2'b10, 0, 4'h3, 2'b10, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b00, 8'h35, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b00, 8'h35, 1, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b01, 8'h21, 0, 2'b01, 1, 4'h1, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b11, 8'h21, 0, 2'b01, 1, 4'h1, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b11, 8'h21, 0, 2'b01, 1, 4'h1, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(1, 2'b11, 8'h21, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b11, 8'h21, 0, 2'b01, 1, 4'h1, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b11, 8'h21, 1, 2'b01, 0, 4'h1, 2'b01, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b10, 8'h21, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));
        tbl.push_back(mkv(0, 2'b10, 8'h21, 0, 2'b10, 1, 4'h2, 2'b00, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b10, 8'h21, 1, 2'b10, 0, 4'h2, 2'b10, 2'b00, 1));
        tbl.push_back(mkv(0, 2'b00, 8'h21, 0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].r; rv = tbl[i].rv; msg = tbl[i].msg; sbdone = tbl[i].sbd;
            ratio = 1'b0;
            tick();
            chk($sformatf("table[%0d]", i), 32'(outs()),
                32'({tbl[i].g, tbl[i].v, tbl[i].m, tbl[i].d, tbl[i].t, tbl[i].b}));
        end
        sbdone = 0; rst = 0;

        // Round robin with both requesters held continuously
        rst = 1; rv = '0; tick(); rst = 0;
        rv = 2'b11; msg = 8'h43;
        for (int m = 0; m < 4; m++) begin
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                tick();
                if (o_grant != '0) got = 1;
            end
            chk($sformatf("rr_grant%0d", m), 32'(o_grant), (m % 2) ? 32'h2 : 32'h1);
            sbdone = 1; tick(); sbdone = 0;
        end
        rv = '0; tick(); tick();

        // Watchdog at both clock ratios
        for (int r = 0; r < 2; r++) begin
            rst = 1; rv = '0; sbdone = 0; tick(); rst = 0;
            ratio = r[0]; rv = 2'b01; msg = 8'h07;
            hi = 0; tos = 0; dns = 0;
            for (int c = 0; c < (r ? 1600 : 800) + 20; c++) begin
                tick();
                if (o_sb_msg_valid) hi++;
                if (o_req_done != '0) dns++;
                if (o_req_timeout != '0) begin
                    tos++;
                    chk($sformatf("wd%0d_to_bits", r), 32'(o_req_timeout), 32'h1);
                    chk($sformatf("wd%0d_valid_at_to", r), 32'(o_sb_msg_valid), 32'h0);
                    rv = '0;
                end
            end
            chk($sformatf("wd%0d_valid_cycles", r), hi, r ? 1600 : 800);
            chk($sformatf("wd%0d_timeouts", r), tos, 1);
            chk($sformatf("wd%0d_dones", r), dns, 0);
        end

        // Done on the last watchdog cycle wins over timeout
        rst = 1; rv = '0; tick(); rst = 0;
        ratio = 0; rv = 2'b01; msg = 8'h04;
        tick();
        for (int c = 0; c < 799; c++) tick();
        chk("wd_edge_valid", 32'(o_sb_msg_valid), 32'h1);
        sbdone = 1; tick(); sbdone = 0;
        chk("wd_edge_done", 32'(o_req_done), 32'h1);
        chk("wd_edge_no_to", 32'(o_req_timeout), 32'h0);
        rv = '0; tick();
        chk("wd_edge_after", 32'(outs()), 32'h0);

        // Randomized traffic against the model
        rst = 1; rv = '0; sbdone = 0; tick();
        model_step();
        chk("rand_reset", 32'(outs()), 32'({e_g, e_v, e_m, e_d, e_t, e_b}));
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!rv[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rv[k] = 1;
                        msg[k*MW +: MW] = 4'($urandom);
                    end
                end else if (o_req_done[k] || o_req_timeout[k]) begin
                    if ($urandom_range(0, 3) != 0) rv[k] = 0;
                end else if ($urandom_range(0, 39) == 0) begin
                    rv[k] = 0;
                end else if ($urandom_range(0, 9) == 0) begin
                    msg[k*MW +: MW] = 4'($urandom);
                end
            end
            sbdone = ($urandom_range(0, 5) == 0);
            ratio  = 1'($urandom);
            rst    = ($urandom_range(0, 299) == 0);
            tick();
            model_step();
            chk($sformatf("rand_cyc%0d", c), 32'(outs()),
                32'({e_g, e_v, e_m, e_d, e_t, e_b}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
